// File: rtl/neural_pkg.sv
// Shared types and constants for the matrix row reader: FSM states, default
// widths and the beat record carried from storage to the output stream.
package neural_pkg;

    localparam int DATA_W = 48;
    localparam int IDX_W  = 32;
    localparam int LANE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  row_index;
        logic              last;
    } row_beat_t;

endpackage

// File: rtl/matrix_row_reader_if.sv
// Bus bundle of the row reader: request handshake, storage read port and
// output stream. "master" is the reader, "slave" is its environment.
interface matrix_row_reader_if #(
    parameter int DATA_W = 48,
    parameter int IDX_W  = 32
);

    logic              req_valid;
    logic              req_ready;
    logic [IDX_W-1:0]  req_layer_index;
    logic [IDX_W-1:0]  req_row_start;
    logic [IDX_W-1:0]  req_row_count;

    logic              mem_rd_en;
    logic [IDX_W-1:0]  mem_layer_index;
    logic [IDX_W-1:0]  mem_row_index;
    logic [DATA_W-1:0] mem_rd_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_row_index;
    logic              out_last;

    modport master (
        input  req_valid, req_layer_index, req_row_start, req_row_count,
        input  mem_rd_data, out_ready,
        output req_ready, mem_rd_en, mem_layer_index, mem_row_index,
        output out_valid, out_data, out_row_index, out_last
    );

    modport slave (
        output req_valid, req_layer_index, req_row_start, req_row_count,
        output mem_rd_data, out_ready,
        input  req_ready, mem_rd_en, mem_layer_index, mem_row_index,
        input  out_valid, out_data, out_row_index, out_last
    );

endinterface

// File: rtl/matrix_row_reader_row_fifo.sv
// row_fifo: synchronous FIFO with flush, arbitrary depth >= 2. Push is
// accepted when full only if a pop happens in the same cycle.
module row_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 81
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array carries payload only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;

endmodule

// File: rtl/matrix_row_reader.sv
// Streams a run of matrix rows from single-cycle-latency storage into a
// buffered valid/ready stream. Optional ROW_READER_CHECKSUM_EN adds a lane checksum.
module matrix_row_reader #(
    parameter int DATA_W     = 48,
    parameter int IDX_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    matrix_row_reader_if.master bus,
    input  logic                abort,
    output logic                busy
`ifdef ROW_READER_CHECKSUM_EN
    ,
    output logic [15:0]         checksum,
    output logic                checksum_valid
`endif
);

    import neural_pkg::*;

    localparam int ENTRY_W = DATA_W + IDX_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  layer_q, layer_d, row_q, row_d, rem_q, rem_d;
    logic [IDX_W-1:0]  rd_row_q, rd_row_d;
    logic              rd_pend_q, rd_pend_d, rd_last_q, rd_last_d;

    logic              req_ready, hs, issue, pop, credit_ok, fifo_push;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used, credit_cap;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic              head_last;
    logic [IDX_W-1:0]  head_row;
    logic [DATA_W-1:0] head_data;

    assign {head_last, head_row, head_data} = head_entry;
    assign push_entry = {rd_last_q, rd_row_q, bus.mem_rd_data};

    // A read is only issued if its return is guaranteed a FIFO slot.
    always_comb begin
        req_ready   = reset_reset_n && (state_q == IDLE) && !abort;
        hs          = bus.req_valid && req_ready;
        pop         = !fifo_empty && bus.out_ready;
        credit_used = {1'b0, fifo_count} + (CNT_W+1)'(rd_pend_q);
        credit_cap  = (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop);
        credit_ok   = credit_used < credit_cap;
        issue       = (state_q == ISSUE) && !abort && credit_ok;
        fifo_push   = rd_pend_q && !abort && (!fifo_full || pop);
    end

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        row_d     = row_q;
        rem_d     = rem_q;
        rd_pend_d = issue;
        rd_row_d  = row_q;
        rd_last_d = (rem_q == IDX_W'(1));
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    layer_d = bus.req_layer_index;
                    row_d   = bus.req_row_start;
                    rem_d   = bus.req_row_count;
                    if (bus.req_row_count != '0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue) begin
                    row_d = row_q + IDX_W'(1);
                    rem_d = rem_q - IDX_W'(1);
                    if (rem_q == IDX_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            layer_q   <= '0;
            row_q     <= '0;
            rem_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_row_q  <= '0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            row_q     <= row_d;
            rem_q     <= rem_d;
            rd_pend_q <= rd_pend_d;
            rd_row_q  <= rd_row_d;
            rd_last_q <= rd_last_d;
        end
    end

    row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_row_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .flush     (abort),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head payload is masked when empty so outputs read zero out of reset.
    assign bus.req_ready       = req_ready;
    assign bus.mem_rd_en       = issue;
    assign bus.mem_layer_index = layer_q;
    assign bus.mem_row_index   = row_q;
    assign bus.out_valid       = !fifo_empty;
    assign bus.out_data        = fifo_empty ? '0 : head_data;
    assign bus.out_row_index   = fifo_empty ? '0 : head_row;
    assign bus.out_last        = !fifo_empty && head_last;
    assign busy                = (state_q != IDLE);

`ifdef ROW_READER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    logic        csum_vld_q, csum_vld_d;

    function automatic logic [LANE_W-1:0] lane_sum(input logic [DATA_W-1:0] d);
        logic [LANE_W-1:0] s;
        s = '0;
        for (int i = 0; i < DATA_W / LANE_W; i++) s = s + d[i*LANE_W +: LANE_W];
        return s;
    endfunction

    always_comb begin
        csum_d     = csum_q;
        csum_vld_d = pop && head_last;
        if (hs)       csum_d = '0;
        else if (pop) csum_d = csum_q + lane_sum(head_data);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            csum_q     <= '0;
            csum_vld_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            csum_vld_q <= csum_vld_d;
        end
    end

    assign checksum       = csum_q;
    assign checksum_valid = csum_vld_q;
`endif

endmodule

// File: tb/tb_matrix_row_reader.sv
// Directed bench for matrix_row_reader; checksum steps run only when
// ROW_READER_CHECKSUM_EN is defined.
module tb_matrix_row_reader;

    import neural_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic abort;
    logic busy;
`ifdef ROW_READER_CHECKSUM_EN
    logic [15:0] checksum;
    logic        checksum_valid;
`endif

    int tests  = 0;
    int fails  = 0;
    int rd_cnt = 0;
    int r0;
    row_beat_t beats[$];

    matrix_row_reader_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus();

    matrix_row_reader #(
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus),
        .abort         (abort),
        .busy          (busy)
`ifdef ROW_READER_CHECKSUM_EN
        ,
        .checksum       (checksum),
        .checksum_valid (checksum_valid)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] rowdata(input logic [31:0] layer, input logic [31:0] row);
        if (layer == 32'd7 && row == 32'd0) return 48'h0001_0002_0003;
        if (layer == 32'd7 && row == 32'd1) return 48'hFFFF_0001_0000;
        return {layer[15:0], row[15:0], ~row[15:0]};
    endfunction

    // Storage model: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= rowdata(bus.mem_layer_index, bus.mem_row_index);
    end

    always @(negedge clk) begin
        row_beat_t b;
        if (rst_n) begin
            if (bus.mem_rd_en) rd_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                b.data      = bus.out_data;
                b.row_index = bus.out_row_index;
                b.last      = bus.out_last;
                beats.push_back(b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [31:0] layer, input logic [31:0] start, input logic [31:0] count);
        bus.req_valid       = 1'b1;
        bus.req_layer_index = layer;
        bus.req_row_start   = start;
        bus.req_row_count   = count;
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 64'(ok), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; abort = 1'b0; bus.out_ready = 1'b0;
        bus.req_valid = 1'b0; bus.req_layer_index = '0;
        bus.req_row_start = '0; bus.req_row_count = '0;
        tick(); tick();
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_last",  64'(bus.out_last),  64'd0);
        check("rst_busy",      64'(busy),          64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_mem_row",   64'(bus.mem_row_index), 64'd0);
`ifdef ROW_READER_CHECKSUM_EN
        check("rst_csum_valid", 64'(checksum_valid), 64'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(bus.req_ready), 64'd1);
        tick();

        // Basic run: layer 2, rows 5..7, full throughput.
        bus.out_ready = 1'b1;
        send_req(32'd2, 32'd5, 32'd3);
        #1;
        check("a_req_ready", 64'(bus.req_ready), 64'd1);
        tick(); bus.req_valid = 1'b0; #1;
        check("a_n1_rd_en",  64'(bus.mem_rd_en), 64'd1);
        check("a_n1_row",    64'(bus.mem_row_index), 64'd5);
        check("a_n1_layer",  64'(bus.mem_layer_index), 64'd2);
        check("a_n1_busy",   64'(busy), 64'd1);
        tick();
        check("a_n2_row",    64'(bus.mem_row_index), 64'd6);
        check("a_n2_outv",   64'(bus.out_valid), 64'd0);
        tick();
        check("a_n3_rd_en",  64'(bus.mem_rd_en), 64'd1);
        check("a_n3_row",    64'(bus.mem_row_index), 64'd7);
        check("a_n3_outv",   64'(bus.out_valid), 64'd1);
        check("a_n3_orow",   64'(bus.out_row_index), 64'd5);
        check("a_n3_data",   64'(bus.out_data), 64'(rowdata(32'd2, 32'd5)));
        check("a_n3_last",   64'(bus.out_last), 64'd0);
        tick();
        check("a_n4_rd_en",  64'(bus.mem_rd_en), 64'd0);
        check("a_n4_orow",   64'(bus.out_row_index), 64'd6);
        check("a_n4_last",   64'(bus.out_last), 64'd0);
        tick();
        check("a_n5_outv",   64'(bus.out_valid), 64'd1);
        check("a_n5_orow",   64'(bus.out_row_index), 64'd7);
        check("a_n5_last",   64'(bus.out_last), 64'd1);
        tick();
        check("a_n6_outv",   64'(bus.out_valid), 64'd0);
        check("a_n6_busy",   64'(busy), 64'd0);
        check("a_n6_ready",  64'(bus.req_ready), 64'd1);

        // Zero-length request.
        tick();
        beats.delete(); r0 = rd_cnt;
        send_req(32'd3, 32'd9, 32'd0);
        #1;
        check("b_req_ready", 64'(bus.req_ready), 64'd1);
        tick(); bus.req_valid = 1'b0; #1;
        check("b_busy",      64'(busy), 64'd0);
        check("b_ready",     64'(bus.req_ready), 64'd1);
        check("b_rd_en",     64'(bus.mem_rd_en), 64'd0);
        tick(); tick();
        check("b_outv",      64'(bus.out_valid), 64'd0);
        check("b_reads",     64'(rd_cnt - r0), 64'd0);
        check("b_beats",     64'(beats.size()), 64'd0);

        // Back-pressure: 10 rows with the consumer stalled for 20 cycles.
        beats.delete(); r0 = rd_cnt;
        bus.out_ready = 1'b0;
        send_req(32'd1, 32'd0, 32'd10);
        #1;
        tick(); bus.req_valid = 1'b0;
        tick(); tick();
        for (int i = 3; i <= 20; i++) begin
            check($sformatf("c_hold_row_%0d", i), 64'(bus.out_row_index), 64'd0);
            if (i < 20) tick();
        end
        check("c_hold_valid", 64'(bus.out_valid), 64'd1);
        check("c_hold_data",  64'(bus.out_data), 64'(rowdata(32'd1, 32'd0)));
        check("c_hold_last",  64'(bus.out_last), 64'd0);
        check("c_reads_4",    64'(rd_cnt - r0), 64'd4);
        bus.out_ready = 1'b1;
        wait_idle("c");
        check("c_nbeats", 64'(beats.size()), 64'd10);
        check("c_reads_10", 64'(rd_cnt - r0), 64'd10);
        for (int i = 0; i < beats.size() && i < 10; i++) begin
            check($sformatf("c_row_%0d", i),  64'(beats[i].row_index), 64'(i));
            check($sformatf("c_data_%0d", i), 64'(beats[i].data), 64'(rowdata(32'd1, 32'(i))));
            check($sformatf("c_last_%0d", i), 64'(beats[i].last), 64'(i == 9));
        end

        // Row index wraps past the top of the index space.
        beats.delete();
        send_req(32'd0, 32'hFFFF_FFFE, 32'd3);
        #1;
        tick(); bus.req_valid = 1'b0;
        wait_idle("d");
        check("d_nbeats", 64'(beats.size()), 64'd3);
        if (beats.size() == 3) begin
            check("d_row0", 64'(beats[0].row_index), 64'hFFFF_FFFE);
            check("d_row1", 64'(beats[1].row_index), 64'hFFFF_FFFF);
            check("d_row2", 64'(beats[2].row_index), 64'h0);
            check("d_last1", 64'(beats[1].last), 64'd0);
            check("d_last2", 64'(beats[2].last), 64'd1);
        end

        // Abort after the second beat, racing a new request.
        tick();
        send_req(32'd4, 32'h20, 32'd8);
        #1;
        tick(); bus.req_valid = 1'b0;
        tick(); tick();
        check("e_beat1_row", 64'(bus.out_row_index), 64'h20);
        tick();
        check("e_beat2_row", 64'(bus.out_row_index), 64'h21);
        tick();
        abort = 1'b1;
        send_req(32'd5, 32'd0, 32'd2);
        #1;
        check("e_abort_ready", 64'(bus.req_ready), 64'd0);
        tick();
        abort = 1'b0; bus.req_valid = 1'b0; #1;
        check("e_outv",  64'(bus.out_valid), 64'd0);
        check("e_rd_en", 64'(bus.mem_rd_en), 64'd0);
        check("e_busy",  64'(busy), 64'd0);
        check("e_ready", 64'(bus.req_ready), 64'd1);
        r0 = rd_cnt;
        tick();
        check("e_f_busy",  64'(busy), 64'd0);
        check("e_f_ready", 64'(bus.req_ready), 64'd1);
        check("e_f_outv",  64'(bus.out_valid), 64'd0);
        tick(); tick();
        check("e_no_reads", 64'(rd_cnt - r0), 64'd0);

        // Reset in the middle of a stalled transfer.
        bus.out_ready = 1'b0;
        send_req(32'd6, 32'd0, 32'd6);
        #1;
        tick(); bus.req_valid = 1'b0;
        repeat (4) tick();
        check("f_pre_outv", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("f_rst_outv",  64'(bus.out_valid), 64'd0);
        check("f_rst_busy",  64'(busy), 64'd0);
        check("f_rst_ready", 64'(bus.req_ready), 64'd0);
        check("f_rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
        tick();
        beats.delete();
        rst_n = 1'b1; bus.out_ready = 1'b1;
        #1;
        check("f_rel_ready", 64'(bus.req_ready), 64'd1);
        tick(); tick(); tick();
        check("f_no_beats", 64'(beats.size()), 64'd0);
        check("f_outv",     64'(bus.out_valid), 64'd0);
        check("f_busy",     64'(busy), 64'd0);

`ifdef ROW_READER_CHECKSUM_EN
        // Checksum over {1,2,3} and {FFFF,1,0} is 0x0006 mod 2^16.
        send_req(32'd7, 32'd0, 32'd2);
        #1;
        tick(); bus.req_valid = 1'b0;
        tick(); tick();
        check("g_n3_cvld", 64'(checksum_valid), 64'd0);
        tick();
        check("g_n4_cvld", 64'(checksum_valid), 64'd0);
        check("g_n4_last", 64'(bus.out_last), 64'd1);
        tick();
        check("g_n5_cvld", 64'(checksum_valid), 64'd1);
        check("g_n5_csum", 64'(checksum), 64'h0006);
        tick();
        check("g_n6_cvld", 64'(checksum_valid), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_row_reader.md
MATRIX_ROW_READER -- requirements
Module: matrix_row_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 48, meaning row width as three 16-bit lanes.
REQ-002 SHALL have parameter IDX_W, default 32, meaning layer and row index width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries; minimum 2.
REQ-004 SHALL have port clk_clk  in  1  single clock, rising edge.
REQ-005 SHALL have port reset_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid in 1 and req_ready out 1, forming the read-request handshake.
REQ-007 SHALL have ports req_layer_index in IDX_W, req_row_start in IDX_W and req_row_count in IDX_W, meaning the layer, first row and number of rows.
REQ-008 SHALL have ports mem_rd_en out 1, mem_layer_index out IDX_W and mem_row_index out IDX_W, forming the storage read address.
REQ-009 SHALL have port mem_rd_data  in  DATA_W  storage row data, valid exactly 1 cycle after mem_rd_en.
REQ-010 SHALL have ports out_valid out 1 and out_ready in 1, forming the stream handshake.
REQ-011 SHALL have ports out_data out DATA_W, out_row_index out IDX_W and out_last out 1, meaning the row payload, its row index and a final-row flag.
REQ-012 SHALL have port abort  in  1  synchronous cancel.
REQ-013 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE and DRAIN.
REQ-015 SHALL assert req_ready only in IDLE with abort low; on req_valid&&req_ready it SHALL latch all request fields.
REQ-016 SHALL go from IDLE to ISSUE on handshake with count>0; with count==0 it SHALL stay in IDLE, issue no reads and emit no beats.
REQ-017 SHALL, in ISSUE, assert mem_rd_en only when FIFO occupancy + in-flight reads − pop-this-cycle < FIFO_DEPTH.
REQ-018 SHALL advance the row index by 1 after each issued read, wrapping modulo 2^IDX_W (0xFFFFFFFF -> 0x0).
REQ-019 SHALL move from ISSUE to DRAIN after issuing the count-th read, and from DRAIN to IDLE when the beat with out_last is accepted.
REQ-020 SHALL, when the request is handshaken in cycle n, assert mem_rd_en in n+1, capture data at the end of n+2 and present out_valid in n+3.
REQ-021 SHALL sustain 1 beat/cycle while out_ready is held high.
REQ-022 SHALL keep out_data, out_row_index and out_last stable while out_valid && !out_ready.
REQ-023 SHALL assert out_last only on the beat of the count-th row.
REQ-024 SHALL, on abort high in any state, flush the FIFO, discard the in-flight return, deassert out_valid and mem_rd_en next cycle, and enter IDLE; abort SHALL win over a simultaneous req_valid.
REQ-025 SHALL never overflow or underflow the FIFO; a push and a pop in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-026 SHALL, while reset_reset_n is low, force state IDLE and drive req_ready=0, mem_rd_en=0, out_valid=0, out_last=0, busy=0, and all data/index outputs and the FIFO pointers to 0.
REQ-027 SHALL assert req_ready in the first cycle after reset release.
REQ-028 SHALL, on reset mid-transfer, abandon the transfer, lose all buffered rows and emit no partial beat.

Configuration
REQ-029 SHALL, with ROW_READER_CHECKSUM_EN defined, add outputs checksum (16 bits) and checksum_valid (1 bit).
REQ-030 SHALL compute checksum as the mod-2^16 sum of all three lanes of every accepted beat, and pulse checksum_valid for 1 cycle after the out_last beat is accepted.
REQ-031 SHALL clear the checksum on each request handshake.
REQ-032 SHALL, without ROW_READER_CHECKSUM_EN, omit both ports and their logic entirely.

Structure
REQ-033 SHALL place the FSM state enum, the DATA_W/IDX_W/LANE_W=16 constants and the row_beat_t struct (data, row_index, last) in shared package neural_pkg.
REQ-034 SHALL implement the buffer as sub-module row_fifo (synchronous FIFO, parameterised depth and width, with push, pop, full, empty and count).

Verification
REQ-035 SHALL cover: layer=2, start=5, count=3, out_ready=1 -> mem_rd_en rows 5,6,7 in cycles n+1..n+3, beats in n+3..n+5, out_last on row 7.
REQ-036 SHALL cover: count=0 -> no mem_rd_en, no out_valid, req_ready high again next cycle.
REQ-037 SHALL cover: count=10, out_ready=0 for 20 cycles -> exactly 4 reads issued, beat row 0 held stable, then all 10 rows delivered in order after release.
REQ-038 SHALL cover: start=0xFFFFFFFE, count=3 -> out_row_index sequence FFFFFFFE, FFFFFFFF, 0.
REQ-039 SHALL cover: abort in the cycle after the 2nd beat of count=8, coincident with req_valid -> out_valid low next cycle, that request not accepted, busy=0 and req_ready=1 in the following cycle.
REQ-040 SHALL cover, with ROW_READER_CHECKSUM_EN: rows {0x0001,0x0002,0x0003} and {0xFFFF,0x0001,0x0000} -> checksum 0x0006 with a 1-cycle checksum_valid pulse.
